rst_seq: RTL and testbench
==========================

// Module: rst_seq
// PURPOSE
//  Parametrised multi-channel reset sequencer; successor to our single-channel 2-flop reset synchronizer.
//  - Synchronizes a raw active-low board reset (push-button or supervisor) and debounces its release.
//  - Releases NUM_CH downstream active-low resets in a fixed order, spaced STAGE_GAP cycles apart.
//  - Adds per-channel software reset pulses.
//  - Sits at the top of the clock domain and feeds every block's rst_n.
// PARAMETERS
//  NUM_CH      3   number of sequenced reset channels (>=1)
//  SYNC_STAGES 2   synchronizer flops on ext_rst_n (>=2)
//  DEBOUNCE    4   consecutive synced-high cycles required before release starts (>=1)
//  STAGE_GAP   3   cycles between release of channel k and channel k+1 (>=1)
//  SW_PULSE    8   cycles a software reset holds a channel low (>=1)
// PORTS
//  clk         in   1       single clock; all logic on posedge
//  rst         in   1       synchronous, active-high power-on reset
//  ext_rst_n   in   1       raw asynchronous active-low reset request; sampled only through the sync chain
//  sw_rst_req  in   NUM_CH  per-channel software reset request; level sampled each cycle
//  rst_n_out   out  NUM_CH  sequenced active-low resets; bit 0 is released first
//  all_released out 1       high while every rst_n_out bit has been released by the sequence (state RUN)
//  busy        out  1       high in every state except RUN
// BEHAVIOUR
//  Reset (rst=1 at posedge)
//   - Sync chain cleared to 0 (reset requested); counters cleared.
//   - State=ASSERT; rst_n_out=0; all_released=0; busy=1.
//  Synchronizer
//   - sync_q is ext_rst_n delayed SYNC_STAGES edges.
//   - Assertion: sync_q=0 in any state -> next edge state=ASSERT, all rst_n_out=0, all counters cleared.
//   - Assertion has priority over every other event.
//  FSM states
//   - ASSERT: outputs all 0. sync_q=1 -> WAIT_STABLE, stable count=1.
//   - WAIT_STABLE: count increments while sync_q=1. Any sync_q=0 -> ASSERT (glitch filter).
//     count==DEBOUNCE at an edge -> RELEASE, and rst_n_out[0] goes 1 on that same edge.
//   - RELEASE: gap counter runs. Every STAGE_GAP cycles the next channel index goes 1.
//     When rst_n_out[NUM_CH-1] goes 1 -> RUN on the same edge.
//     NUM_CH=1: ASSERT -> WAIT_STABLE -> RUN directly; ch0 released on entry to RUN.
//   - RUN: all_released=1, busy=0.
//  Latency
//   - Raw ext_rst_n rising captured at edge E0 -> rst_n_out[0]=1 at edge E0+SYNC_STAGES+DEBOUNCE.
//   - Channel k rises k*STAGE_GAP edges after channel 0.
//  Released channels
//   - Never re-asserted during RELEASE except by sync_q=0 or rst.
//   - Output order is monotonic: bit k is never 1 while bit k-1 is 0, except during a software pulse.
//  Software reset (honoured only in RUN)
//   - sw_rst_req[i]=1 -> rst_n_out[i]=0 from next edge for SW_PULSE cycles, then 1.
//   - Request while channel i's pulse is active restarts its count (retrigger).
//   - Simultaneous requests on several channels run independently.
//   - all_released=0 and busy=1 while any pulse is active; state stays RUN.
//   - Requests in ASSERT, WAIT_STABLE or RELEASE are ignored (not queued).
//   - sync_q=0 during a pulse cancels the pulse; the channel re-enters the normal sequence.
//  Width rules
//   - Counters sized $clog2(max+1); saturate, never wrap.
//   - gap counter clears on each channel release.
// STRUCTURE
//  - Package rst_seq_pkg: state enum typedef (ASSERT, WAIT_STABLE, RELEASE, RUN); parameter legality
//    checks as elaboration-time assertions.
//  - Sub-module sync_chain (parametrised SYNC_STAGES, sync active-high reset value 0): instantiated once for
//    ext_rst_n.
//  - Per-channel pulse counters in a generate loop inside rst_seq.
// TESTING  (NUM_CH=3, SYNC_STAGES=2, DEBOUNCE=4, STAGE_GAP=3, SW_PULSE=8)
//  1. rst=1 two cycles, ext_rst_n=1 -> during rst: rst_n_out=000, busy=1.
//     After rst: ch0=1 @E+6, ch1 @E+9, ch2 @E+12; all_released=1 @E+12.
//  2. Glitch: ext_rst_n low, then high 3 cycles, then low -> rst_n_out stays 000, state never leaves
//     ASSERT/WAIT_STABLE.
//  3. ext_rst_n drops to 0 in RELEASE after ch0 released -> 2 edges later rst_n_out=000.
//     Re-release restarts full timing from 1.
//  4. In RUN, sw_rst_req=3'b010 one cycle -> rst_n_out=101 for 8 cycles, then 111.
//     all_released low during pulse, busy high.
//  5. Retrigger: sw_rst_req[1] pulses at t and t+5 -> ch1 low until t+13.
//     Same-cycle req on ch0 and ch2 -> both low 8 cycles.
//  6. sw_rst_req=111 held during WAIT_STABLE/RELEASE -> ignored, release timing identical to test 1.
//     rst=1 mid-RELEASE -> next edge rst_n_out=000, state ASSERT.

Source files
------------

// File: rtl/rst_seq_pkg.sv
// Shared types and parameter legality helper for the multi-channel reset sequencer.
package rst_seq_pkg;

  typedef enum logic [1:0] {
    ASSERT      = 2'd0,
    WAIT_STABLE = 2'd1,
    RELEASE     = 2'd2,
    RUN         = 2'd3
  } state_t;

  function automatic bit params_ok(input int num_ch, input int sync_stages, input int debounce,
                                   input int stage_gap, input int sw_pulse);
    return (num_ch >= 1) && (sync_stages >= 2) && (debounce >= 1) &&
           (stage_gap >= 1) && (sw_pulse >= 1);
  endfunction

endpackage

// File: rtl/rst_seq_sync.sv
// Multi-flop synchronizer; clears to 0 so a power-on reset reads as "board reset requested".
module sync_chain #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain_reg;

  always_ff @(posedge clk) begin
    if (rst) chain_reg <= '0;
    else     chain_reg <= {chain_reg[STAGES-2:0], d};
  end

  assign q = chain_reg[STAGES-1];

endmodule

// File: rtl/rst_seq.sv
// Reset sequencer: synchronizes/debounces the board reset, releases NUM_CH resets in order,
// and adds per-channel retriggerable software reset pulses while running.
module rst_seq
  import rst_seq_pkg::*;
#(
  parameter int NUM_CH      = 3,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE    = 4,
  parameter int STAGE_GAP   = 3,
  parameter int SW_PULSE    = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ext_rst_n,
  input  logic [NUM_CH-1:0] sw_rst_req,
  output logic [NUM_CH-1:0] rst_n_out,
  output logic              all_released,
  output logic              busy
);

  localparam int STW = $clog2(DEBOUNCE + 1);
  localparam int GW  = $clog2(STAGE_GAP + 1);
  localparam int PW  = $clog2(SW_PULSE + 1);

  if (!params_ok(NUM_CH, SYNC_STAGES, DEBOUNCE, STAGE_GAP, SW_PULSE)) begin : g_bad_params
    $error("rst_seq: illegal parameter set");
  end

  logic              sync_q;
  state_t            state_reg, state_next;
  logic [STW-1:0]    stable_reg, stable_next;
  logic [GW-1:0]     gap_reg, gap_next;
  logic [NUM_CH-1:0] rel_reg, rel_next;
  logic [NUM_CH-1:0] pulse_active_next;
  logic [NUM_CH-1:0] rst_n_reg;
  logic              all_rel_reg, busy_reg;

  sync_chain #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (ext_rst_n),
    .q   (sync_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= ASSERT;
      stable_reg <= '0;
      gap_reg    <= '0;
      rel_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      stable_reg <= stable_next;
      gap_reg    <= gap_next;
      rel_reg    <= rel_next;
    end
  end

  // rel_reg is a thermometer mask of released channels; each release shifts in one more 1.
  always_comb begin
    state_next  = state_reg;
    stable_next = stable_reg;
    gap_next    = gap_reg;
    rel_next    = rel_reg;
    if (!sync_q) begin
      state_next  = ASSERT;
      stable_next = '0;
      gap_next    = '0;
      rel_next    = '0;
    end else begin
      case (state_reg)
        ASSERT: begin
          state_next  = WAIT_STABLE;
          stable_next = STW'(1);
        end
        WAIT_STABLE: begin
          if (stable_reg == STW'(DEBOUNCE)) begin
            rel_next   = NUM_CH'(1);
            gap_next   = '0;
            state_next = (NUM_CH == 1) ? RUN : RELEASE;
          end else if (stable_reg < STW'(DEBOUNCE)) begin
            stable_next = stable_reg + 1'b1;
          end
        end
        RELEASE: begin
          if (gap_reg >= GW'(STAGE_GAP - 1)) begin
            rel_next = NUM_CH'({rel_reg, 1'b1});
            gap_next = '0;
            if (rel_next[NUM_CH-1]) state_next = RUN;
          end else begin
            gap_next = gap_reg + 1'b1;
          end
        end
        RUN:     state_next = RUN;
        default: state_next = ASSERT;
      endcase
    end
  end

  for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_pulse
    logic [PW-1:0] cnt_reg, cnt_next;

    // A new request reloads the full width, so retriggers extend the pulse.
    always_comb begin
      cnt_next = cnt_reg;
      if (!sync_q)
        cnt_next = '0;
      else if (state_reg == RUN && sw_rst_req[gi])
        cnt_next = PW'(SW_PULSE);
      else if (cnt_reg != '0)
        cnt_next = cnt_reg - 1'b1;
    end

    always_ff @(posedge clk) begin
      if (rst) cnt_reg <= '0;
      else     cnt_reg <= cnt_next;
    end

    assign pulse_active_next[gi] = (cnt_next != '0);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rst_n_reg   <= '0;
      all_rel_reg <= 1'b0;
      busy_reg    <= 1'b1;
    end else begin
      rst_n_reg   <= rel_next & ~pulse_active_next;
      all_rel_reg <= (state_next == RUN) && (pulse_active_next == '0);
      busy_reg    <= !((state_next == RUN) && (pulse_active_next == '0));
    end
  end

  assign rst_n_out    = rst_n_reg;
  assign all_released = all_rel_reg;
  assign busy         = busy_reg;

endmodule

// File: tb/tb_rst_seq.sv
// Self-checking bench for rst_seq: directed timing scenarios plus randomized traffic against
// an event-count reference model.
module tb_rst_seq;

  localparam int N      = 3;
  localparam int S      = 2;
  localparam int D      = 4;
  localparam int G      = 3;
  localparam int P      = 8;
  localparam int RUN_AT = D + 1 + (N - 1) * G;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         ext_rst_n = 1'b1;
  logic [N-1:0] sw_rst_req = '0;
  logic [N-1:0] rst_n_out;
  logic         all_released;
  logic         busy;

  always #5 clk = ~clk;

  rst_seq #(
    .NUM_CH(N), .SYNC_STAGES(S), .DEBOUNCE(D), .STAGE_GAP(G), .SW_PULSE(P)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ext_rst_n    (ext_rst_n),
    .sw_rst_req   (sw_rst_req),
    .rst_n_out    (rst_n_out),
    .all_released (all_released),
    .busy         (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Reference model: delayed view of ext_rst_n, count of consecutive synced-high edges,
  // and remaining software pulse cycles per channel.
  logic [S-1:0] ext_hist;
  int           high_run;
  int           rem[N];

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic [N-1:0] model_rst_n();
    logic [N-1:0] v;
    for (int k = 0; k < N; k++) v[k] = (high_run >= D + 1 + k * G) && (rem[k] == 0);
    return v;
  endfunction

  function automatic logic model_all_rel();
    logic ok;
    ok = (high_run >= RUN_AT);
    for (int k = 0; k < N; k++) if (rem[k] != 0) ok = 1'b0;
    return ok;
  endfunction

  task automatic model_edge(input logic r, input logic e, input logic [N-1:0] q);
    logic s;
    logic was_run;
    if (r) begin
      ext_hist = '0;
      high_run = 0;
      for (int k = 0; k < N; k++) rem[k] = 0;
    end else begin
      s       = ext_hist[S-1];
      was_run = (high_run >= RUN_AT);
      for (int k = 0; k < N; k++) begin
        if (!s)                  rem[k] = 0;
        else if (was_run && q[k]) rem[k] = P;
        else if (rem[k] > 0)     rem[k] = rem[k] - 1;
      end
      high_run = s ? high_run + 1 : 0;
      if (high_run > RUN_AT) high_run = RUN_AT;
      ext_hist = {ext_hist[S-2:0], e};
    end
  endtask

  // One clock: drive inputs, let the edge happen, compare DUT with the model on the falling edge.
  task automatic step(input logic r, input logic e, input logic [N-1:0] q);
    rst = r; ext_rst_n = e; sw_rst_req = q;
    @(posedge clk);
    model_edge(r, e, q);
    @(negedge clk);
    check_val("rst_n_out", 32'(rst_n_out), 32'(model_rst_n()));
    check_val("all_released", 32'(all_released), 32'(model_all_rel()));
    check_val("busy", 32'(busy), 32'(!model_all_rel()));
  endtask

  // Release from a cleared synchronizer: ch0 at step 7, ch1 at 10, ch2 and RUN at 13.
  task automatic latency_run(input string tag, input logic [N-1:0] q_hold);
    logic [N-1:0] exp;
    for (int i = 1; i <= 14; i++) begin
      step(1'b0, 1'b1, (i <= 13) ? q_hold : '0);
      exp = (i >= 13) ? 3'b111 : (i >= 10) ? 3'b011 : (i >= 7) ? 3'b001 : 3'b000;
      check_val(tag, 32'(rst_n_out), 32'(exp));
      check_val({tag, "_all"}, 32'(all_released), 32'(i >= 13));
    end
    $display("%s: release sequence done", tag);
  endtask

  initial begin
    logic         e;
    logic [N-1:0] q;
    logic [N-1:0] exp;

    @(negedge clk);
    // 1. power-on reset then clean release
    step(1'b1, 1'b1, '0);
    check_val("t1_rst_out", 32'(rst_n_out), 32'(0));
    check_val("t1_rst_busy", 32'(busy), 32'(1));
    step(1'b1, 1'b1, '0);
    latency_run("t1_lat", '0);

    // 4. single software pulse on ch1
    for (int j = 0; j <= 8; j++) begin
      step(1'b0, 1'b1, (j == 0) ? 3'b010 : 3'b000);
      exp = (j < 8) ? 3'b101 : 3'b111;
      check_val("t4_pulse", 32'(rst_n_out), 32'(exp));
      check_val("t4_busy", 32'(busy), 32'(j < 8));
    end
    $display("t4: software pulse done");

    // 5. retrigger on ch1, then simultaneous ch0+ch2
    for (int j = 0; j <= 14; j++) begin
      step(1'b0, 1'b1, (j == 0 || j == 5) ? 3'b010 : 3'b000);
      check_val("t5_retrig", 32'(rst_n_out[1]), 32'(j >= 13));
    end
    for (int j = 0; j <= 9; j++) begin
      step(1'b0, 1'b1, (j == 0) ? 3'b101 : 3'b000);
      exp = (j < 8) ? 3'b010 : 3'b111;
      check_val("t5_dual", 32'(rst_n_out), 32'(exp));
    end
    $display("t5: retrigger and dual pulse done");

    // 3. board reset drops mid-RELEASE; outputs clear two edges after capture
    step(1'b1, 1'b1, '0);
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, '0);
    check_val("t3_ch0_up", 32'(rst_n_out), 32'(3'b001));
    for (int i = 1; i <= 5; i++) begin
      step(1'b0, 1'b0, '0);
      if (i >= 3) check_val("t3_drop", 32'(rst_n_out), 32'(0));
    end
    latency_run("t3_lat", '0);

    // 2. glitch: 3 high cycles never reach release
    for (int i = 1; i <= 13; i++) begin
      step(1'b0, (i >= 5 && i <= 7) ? 1'b1 : 1'b0, '0);
      if (i >= 3) begin
        check_val("t2_glitch", 32'(rst_n_out), 32'(0));
        check_val("t2_busy", 32'(busy), 32'(1));
      end
    end
    $display("t2: glitch filtered");

    // 6. requests held before RUN are ignored; rst mid-RELEASE clears outputs
    step(1'b1, 1'b1, '0);
    latency_run("t6_lat", 3'b111);
    step(1'b1, 1'b1, '0);
    for (int i = 1; i <= 8; i++) step(1'b0, 1'b1, '0);
    step(1'b1, 1'b1, '0);
    check_val("t6_rst_mid", 32'(rst_n_out), 32'(0));
    check_val("t6_rst_busy", 32'(busy), 32'(1));
    $display("t6: ignored requests and mid-release reset done");

    // randomized traffic
    e = 1'b1;
    for (int c = 0; c < 1500; c++) begin
      if (e) e = ($urandom_range(0, 99) != 0);
      else   e = ($urandom_range(0, 3) == 0);
      for (int k = 0; k < N; k++) q[k] = ($urandom_range(0, 11) == 0);
      step(($urandom_range(0, 299) == 0), e, q);
    end
    $display("random: 1500 cycles done");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
